dna_match_controller: RTL and testbench
=======================================

# dna_match_controller

Sequencing controller for the 64-bit DNA word comparator. On a start request it walks a window of reference-sequence words in memory, presents each word with the search key to an external comparator, and reports every matching address through a valid/ready handshake. It also keeps a saturating match count. It sits between the reference-sequence memory and the comparator, beneath the host/command logic.

## Interface
- ADDR_W, 16, width of word addresses, word count and match count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin search; accepted only in IDLE
- abort  in  1  synchronous; returns to IDLE from any state
- base_addr  in  ADDR_W  first word address, latched at start
- num_words  in  ADDR_W  words to search, latched at start
- key  in  64  search key, latched at start
- key_mask  in  64  don't-care bits, latched at start; present only with MATCH_MASK_EN
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  64  read data, valid exactly 1 cycle after mem_rd_en
- cmp_data  out  64  data operand to comparator
- cmp_key  out  64  key operand to comparator
- cmp_match  in  1  comparator result, combinational from cmp_data/cmp_key
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- match_valid  out  1  match report valid
- match_ready  in  1  consumer accepts report
- match_addr  out  ADDR_W  address of the matching word
- match_count  out  ADDR_W  matches in current/last search, saturating

Reset: all outputs 0, state IDLE, internal registers 0.

## Operation
- States: IDLE, READ, CAPTURE, COMPARE, REPORT, DONE.
- IDLE: start=1 latches base_addr, num_words, key (and key_mask), clears idx and match_count. Next state is READ, or DONE if num_words==0.
- READ: mem_rd_en=1, mem_addr=base_q+idx (mod 2^ADDR_W, wraps silently) -> CAPTURE.
- CAPTURE: data_q <= mem_rd_data -> COMPARE.
- COMPARE: cmp_data/cmp_key from registers; sample cmp_match.
  - Match: match_count += 1, saturating at all-ones. match_addr <= base_q+idx. Next state REPORT.
  - No match: if idx==num_q-1, go DONE; else idx+=1 and go READ.
- REPORT: match_valid=1 and match_addr are held stable until match_ready=1. On the handshake cycle, match_valid drops next cycle. Then DONE if last word, else idx+=1 and READ.
- DONE: done=1 for exactly one cycle -> IDLE. match_count holds until the next start.
- start outside IDLE is ignored. Latched inputs may change freely after start.
- abort: highest priority. Next state IDLE with busy=0, match_valid=0, mem_rd_en=0, and no done pulse. match_count keeps its value.
- Reset mid-search: immediate return to reset values; no done pulse.

## Timing
- Non-matching word: 3 cycles (READ, CAPTURE, COMPARE).
- Matching word: 4 cycles plus consumer stall cycles.
- start at edge t: busy=1 and mem_rd_en=1 from t+1. First compare happens at t+3.
- done asserts the cycle after the final COMPARE or REPORT handshake.
- num_words==0: done in cycle t+1, mem_rd_en never asserted.
- cmp_key is registered (key_q) and stable for the whole search.

## Configuration
- MATCH_MASK_EN defined:
  - key_mask port exists and is latched at start as mask_q.
  - cmp_data = data_q | mask_q and cmp_key = key_q | mask_q, so masked bits always compare equal. This supports variation/wildcard detection.
- Undefined:
  - No key_mask port.
  - cmp_data = data_q and cmp_key = key_q, giving an exact match only.

## Test plan
- Reset: rst_n low mid-READ -> all outputs 0 immediately; after release, busy=0 and done never pulses.
- Basic search: base=0x0010, num=4, key matching words at 0x0011 and 0x0013, match_ready tied 1 -> reports 0x0011 then 0x0013, match_count=2, one done pulse, 14 cycles from start to done.
- Backpressure and wrap: base=0xFFFE, num=3, match at 0xFFFF and 0x0000, match_ready held low 5 cycles -> match_addr stable and valid held through the stall; addresses read are 0xFFFE, 0xFFFF, 0x0000.
- Degenerate and ignored commands: num=0 -> done at t+1, no reads. start pulsed while busy -> ignored, latched parameters unchanged.
- Abort: abort in REPORT -> IDLE next cycle, match_valid=0, no done, match_count retained.
- MATCH_MASK_EN: key_mask=0x00000000_0000FFFF with data differing only in the low 16 bits -> match reported. Same stimulus with the macro undefined -> no match.

Source files
------------

// File: rtl/dna_match_controller_if.sv
// Memory-read and match-report signals of the DNA match controller.
// master: the controller; slave: the memory/report-consumer side.
interface dna_match_controller_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rd_data;
    logic              match_valid;
    logic              match_ready;
    logic [ADDR_W-1:0] match_addr;

    modport master (
        output mem_rd_en, mem_addr, match_valid, match_addr,
        input  mem_rd_data, match_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, match_valid, match_addr,
        output mem_rd_data, match_ready
    );
endinterface

// File: rtl/dna_match_controller.sv
// Sequencing controller for the 64-bit DNA word comparator.
// Walks a window of reference words, presents each with the search key to an
// external comparator and reports matching addresses over a valid/ready port.
// Optional feature: define MATCH_MASK_EN to add the key_mask don't-care port.
module dna_match_controller #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [63:0]       key,
`ifdef MATCH_MASK_EN
    input  logic [63:0]       key_mask,
`endif
    output logic [63:0]       cmp_data,
    output logic [63:0]       cmp_key,
    input  logic              cmp_match,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] match_count,
    dna_match_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_COMPARE, S_REPORT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [63:0]       key_q, key_d;
    logic [63:0]       data_q, data_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] match_addr_q, match_addr_d;
`ifdef MATCH_MASK_EN
    logic [63:0]       mask_q, mask_d;
`endif

    logic [ADDR_W-1:0] cur_addr;
    logic              last_word;

    assign cur_addr  = base_q + idx_q;  // wraps modulo 2^ADDR_W
    assign last_word = (idx_q == num_q - ADDR_W'(1));

    // Comparator operands come straight from registers; masked bits are forced equal.
`ifdef MATCH_MASK_EN
    assign cmp_data = data_q | mask_q;
    assign cmp_key  = key_q | mask_q;
`else
    assign cmp_data = data_q;
    assign cmp_key  = key_q;
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign match_count     = count_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.match_valid = valid_q;
    assign bus.match_addr  = match_addr_q;

    // Next-state and next-output computation for the search sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        idx_d        = idx_q;
        key_d        = key_q;
        data_d       = data_q;
        count_d      = count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_en_d      = 1'b0;
        mem_addr_d   = mem_addr_q;
        valid_d      = valid_q;
        match_addr_d = match_addr_q;
`ifdef MATCH_MASK_EN
        mask_d       = mask_q;
`endif
        if (abort) begin
            // Abort wins over everything: quiet return, count retained, no done.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_d  = base_addr;
                        num_d   = num_words;
                        key_d   = key;
`ifdef MATCH_MASK_EN
                        mask_d  = key_mask;
`endif
                        idx_d   = '0;
                        count_d = '0;
                        busy_d  = 1'b1;
                        if (num_words == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = S_READ;
                            rd_en_d    = 1'b1;
                            mem_addr_d = base_addr;
                        end
                    end
                end
                S_READ: state_d = S_CAPTURE;
                S_CAPTURE: begin
                    data_d  = bus.mem_rd_data;
                    state_d = S_COMPARE;
                end
                S_COMPARE: begin
                    if (cmp_match) begin
                        if (count_q != '1) count_d = count_q + ADDR_W'(1);
                        match_addr_d = cur_addr;
                        valid_d      = 1'b1;
                        state_d      = S_REPORT;
                    end else if (last_word) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q + ADDR_W'(1);
                        mem_addr_d = cur_addr + ADDR_W'(1);
                        rd_en_d    = 1'b1;
                        state_d    = S_READ;
                    end
                end
                S_REPORT: begin
                    if (bus.match_ready) begin
                        valid_d = 1'b0;
                        if (last_word) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d      = idx_q + ADDR_W'(1);
                            mem_addr_d = cur_addr + ADDR_W'(1);
                            rd_en_d    = 1'b1;
                            state_d    = S_READ;
                        end
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            key_q        <= '0;
            data_q       <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= 1'b0;
            match_addr_q <= '0;
`ifdef MATCH_MASK_EN
            mask_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            key_q        <= key_d;
            data_q       <= data_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            mem_addr_q   <= mem_addr_d;
            valid_q      <= valid_d;
            match_addr_q <= match_addr_d;
`ifdef MATCH_MASK_EN
            mask_q       <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_dna_match_controller.sv
// Directed testbench for dna_match_controller (builds with or without MATCH_MASK_EN).
module tb_dna_match_controller;

    typedef logic [15:0] addr_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic [63:0] key = '0;
`ifdef MATCH_MASK_EN
    logic [63:0] key_mask = '0;
`endif
    logic [63:0] cmp_data, cmp_key;
    logic        cmp_match;
    logic        busy, done;
    logic [15:0] match_count;

    dna_match_controller_if #(.ADDR_W(16)) bus ();

    dna_match_controller #(.ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .key         (key),
`ifdef MATCH_MASK_EN
        .key_mask    (key_mask),
`endif
        .cmp_data    (cmp_data),
        .cmp_key     (cmp_key),
        .cmp_match   (cmp_match),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Reference comparator: exact equality of the presented operands.
    assign cmp_match = (cmp_data == cmp_key);

    // Reference memory: one-cycle read latency.
    logic [63:0] mem [logic [15:0]];
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rd_data <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'h0;
    end

    // Monitor: reads, accepted reports and done pulses, sampled on the falling edge.
    int      cyc = 0;
    addr_q_t reads;
    addr_q_t reports;
    int      done_cnt = 0;
    int      done_cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_rd_en) reads.push_back(bus.mem_addr);
            if (bus.match_valid && bus.match_ready) reports.push_back(bus.match_addr);
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int start_edge;
    int mark_rd, mark_rep, mark_done;

    localparam logic [63:0] K1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] K2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] K3 = 64'h5555_AAAA_3333_CCCC;

    task automatic snap();
        mark_rd   = reads.size();
        mark_rep  = reports.size();
        mark_done = done_cnt;
    endtask

    function automatic addr_q_t tail(addr_q_t q, int from);
        addr_q_t r;
        for (int i = from; i < q.size(); i++) r.push_back(q[i]);
        return r;
    endfunction

    function automatic bit same(addr_q_t a, addr_q_t b);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Issue a start, then scramble the inputs to prove they were latched.
    task automatic launch(input logic [15:0] b, input logic [15:0] n, input logic [63:0] k);
        @(posedge clk); #1;
        base_addr = b; num_words = n; key = k; start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 16'hA5A5; num_words = 16'h7777; key = ~k;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == mark_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (done_cnt == mark_done) $display("FAIL done_timeout: no done within %0d cycles", budget);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.match_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (!bus.match_valid) $display("FAIL valid_timeout: no match_valid within %0d cycles", budget);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        int busy_seen = 0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({busy, done, bus.mem_rd_en, bus.match_valid, bus.mem_addr, bus.match_addr,
             match_count, cmp_data, cmp_key} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b valid=%b count=%h (want all 0)",
                     busy, done, bus.mem_rd_en, bus.match_valid, match_count);
        else pass_cnt++;
        rst_n = 1'b1;
        mem[16'h0010] = K1;
        bus.match_ready = 1'b1;
        launch(16'h0010, 16'd4, K1);
        @(negedge clk);
        chk_cnt++;
        if (bus.mem_rd_en !== 1'b1) $display("FAIL reset_in_read: mem_rd_en=%b want 1", bus.mem_rd_en);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, done, bus.mem_rd_en, bus.match_valid, bus.mem_addr, bus.match_addr,
             match_count, cmp_data, cmp_key} !== '0)
            $display("FAIL reset_async: busy=%b rd=%b addr=%h key=%h (want all 0)",
                     busy, bus.mem_rd_en, bus.mem_addr, cmp_key);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk_cnt++;
        if (busy_seen != 0) $display("FAIL reset_busy_after: busy high %0d cycles want 0", busy_seen);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != mark_done) $display("FAIL reset_no_done: done pulses %0d want 0", done_cnt - mark_done);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        addr_q_t exp_rd  = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        addr_q_t exp_rep = '{16'h0011, 16'h0013};
        mem[16'h0010] = K1 ^ 64'h1;
        mem[16'h0011] = K1;
        mem[16'h0012] = K1 ^ 64'h100;
        mem[16'h0013] = K1;
        bus.match_ready = 1'b1;
        snap();
        launch(16'h0010, 16'd4, K1);
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b1 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 16'h0010)
            $display("FAIL basic_first_read: busy=%b rd=%b addr=%h want 1 1 0010",
                     busy, bus.mem_rd_en, bus.mem_addr);
        else pass_cnt++;
        wait_done(60);
        chk_cnt++;
        if (done_cyc - start_edge != 14) $display("FAIL basic_latency: %0d cycles want 14", done_cyc - start_edge);
        else pass_cnt++;
        chk_cnt++;
        if (!same(tail(reports, mark_rep), exp_rep))
            $display("FAIL basic_reports: got %p want %p", tail(reports, mark_rep), exp_rep);
        else pass_cnt++;
        chk_cnt++;
        if (!same(tail(reads, mark_rd), exp_rd))
            $display("FAIL basic_reads: got %p want %p", tail(reads, mark_rd), exp_rd);
        else pass_cnt++;
        chk_cnt++;
        if (match_count !== 16'd2) $display("FAIL basic_count: got %0d want 2", match_count);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - mark_done != 1 || busy !== 1'b0)
            $display("FAIL basic_done_once: pulses %0d busy=%b want 1 0", done_cnt - mark_done, busy);
        else pass_cnt++;
        chk_cnt++;
        if (cmp_key !== K1) $display("FAIL basic_key_latched: got %h want %h", cmp_key, K1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure_wrap();
        addr_q_t exp_rd  = '{16'hFFFE, 16'hFFFF, 16'h0000};
        addr_q_t exp_rep = '{16'hFFFF, 16'h0000};
        int      stall_bad = 0;
        mem[16'hFFFE] = ~K2;
        mem[16'hFFFF] = K2;
        mem[16'h0000] = K2;
        bus.match_ready = 1'b0;
        snap();
        launch(16'hFFFE, 16'd3, K2);
        wait_valid(40);
        repeat (5) begin
            @(negedge clk);
            if (bus.match_valid !== 1'b1 || bus.match_addr !== 16'hFFFF) stall_bad++;
        end
        chk_cnt++;
        if (stall_bad != 0) $display("FAIL bp_stall_hold: %0d bad cycles valid=%b addr=%h want 0",
                                     stall_bad, bus.match_valid, bus.match_addr);
        else pass_cnt++;
        @(posedge clk); #1 bus.match_ready = 1'b1;
        wait_done(60);
        chk_cnt++;
        if (!same(tail(reports, mark_rep), exp_rep))
            $display("FAIL bp_reports: got %p want %p", tail(reports, mark_rep), exp_rep);
        else pass_cnt++;
        chk_cnt++;
        if (!same(tail(reads, mark_rd), exp_rd))
            $display("FAIL bp_wrap_reads: got %p want %p", tail(reads, mark_rd), exp_rd);
        else pass_cnt++;
        chk_cnt++;
        if (match_count !== 16'd2 || done_cnt - mark_done != 1)
            $display("FAIL bp_count_done: count %0d pulses %0d want 2 1", match_count, done_cnt - mark_done);
        else pass_cnt++;
    endtask

    task automatic test_zero_and_ignored();
        addr_q_t exp_rd  = '{16'h0020, 16'h0021};
        addr_q_t exp_rep = '{16'h0021};
        snap();
        launch(16'h0100, 16'd0, K1);
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b1 || busy !== 1'b1 || match_count !== 16'd0)
            $display("FAIL zero_done_t1: done=%b busy=%b count=%0d want 1 1 0", done, busy, match_count);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (reads.size() != mark_rd || done_cnt - mark_done != 1 || busy !== 1'b0)
            $display("FAIL zero_no_reads: reads %0d pulses %0d busy=%b want 0 1 0",
                     reads.size() - mark_rd, done_cnt - mark_done, busy);
        else pass_cnt++;

        mem[16'h0020] = ~K3;
        mem[16'h0021] = K3;
        for (int i = 16'h40; i < 16'h45; i++) mem[16'(i)] = K1;
        bus.match_ready = 1'b1;
        snap();
        launch(16'h0020, 16'd2, K3);
        base_addr = 16'h0040; num_words = 16'd5; key = K1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(60);
        chk_cnt++;
        if (!same(tail(reads, mark_rd), exp_rd))
            $display("FAIL ignored_reads: got %p want %p", tail(reads, mark_rd), exp_rd);
        else pass_cnt++;
        chk_cnt++;
        if (!same(tail(reports, mark_rep), exp_rep) || match_count !== 16'd1)
            $display("FAIL ignored_reports: got %p count %0d want %p 1", tail(reports, mark_rep), match_count, exp_rep);
        else pass_cnt++;
        chk_cnt++;
        if (cmp_key !== K3 || done_cnt - mark_done != 1)
            $display("FAIL ignored_key: key %h pulses %0d want %h 1", cmp_key, done_cnt - mark_done, K3);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        mem[16'h0030] = K1;
        mem[16'h0031] = K1;
        mem[16'h0032] = K1;
        bus.match_ready = 1'b0;
        snap();
        launch(16'h0030, 16'd3, K1);
        wait_valid(40);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || bus.match_valid !== 1'b0 || bus.mem_rd_en !== 1'b0)
            $display("FAIL abort_idle: busy=%b valid=%b rd=%b want 0 0 0", busy, bus.match_valid, bus.mem_rd_en);
        else pass_cnt++;
        chk_cnt++;
        if (match_count !== 16'd1) $display("FAIL abort_count_kept: got %0d want 1", match_count);
        else pass_cnt++;
        bus.match_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk_cnt++;
        if (done_cnt != mark_done || reports.size() != mark_rep || busy !== 1'b0)
            $display("FAIL abort_quiet: pulses %0d reports %0d busy=%b want 0 0 0",
                     done_cnt - mark_done, reports.size() - mark_rep, busy);
        else pass_cnt++;
    endtask

    task automatic test_mask();
`ifdef MATCH_MASK_EN
        addr_q_t exp_rep = '{16'h0050};
        logic [15:0] exp_cnt = 16'd1;
        key_mask = 64'h0000_0000_0000_FFFF;
`else
        addr_q_t exp_rep = {};
        logic [15:0] exp_cnt = 16'd0;
`endif
        mem[16'h0050] = K1 ^ 64'h0000_0000_0000_5A5A;
        bus.match_ready = 1'b1;
        snap();
        launch(16'h0050, 16'd1, K1);
`ifdef MATCH_MASK_EN
        key_mask = '0;
`endif
        wait_done(40);
        chk_cnt++;
        if (!same(tail(reports, mark_rep), exp_rep))
            $display("FAIL mask_reports: got %p want %p", tail(reports, mark_rep), exp_rep);
        else pass_cnt++;
        chk_cnt++;
        if (match_count !== exp_cnt) $display("FAIL mask_count: got %0d want %0d", match_count, exp_cnt);
        else pass_cnt++;
    endtask

    initial begin
        bus.match_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure_wrap();
        test_zero_and_ignored();
        test_abort();
        test_mask();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
